f_fetch_unit: RTL
=================

// Module: f_fetch_unit
// PURPOSE
//   F-stage of the 5-stage MIPS pipeline: owns the fetch PC, drives the instruction-memory
//   request/ready port, and holds the F/D pipeline register (D_PC, D_instr, D_valid).
//   Consumes the D-stage NPC result (D_NPC_PCnext) for control transfers.
//   Branch delay slot is architectural: branch/jump targets never flush the slot.
//   Tolerates variable IM latency and hazard stalls through a 1-entry skid buffer
//   and a latched redirect.
// PARAMETERS
//   RESET_PC  32'h0000_3000  fetch address after reset
//   NOP_INSTR 32'h0000_0000  instruction word written into D on bubbles
// PORTS
//   clk           in   1   system clock, all state on rising edge
//   reset         in   1   synchronous, active-high
//   F_stall       in   1   hazard unit: hold PC and F/D register this cycle
//   D_jump        in   1   instr in D is a control transfer; D_NPC_PCnext valid (gated by D_valid upstream)
//   D_NPC_PCnext  in   32  target PC from the D-stage NPC
//   i_req         out  1   IM request; address valid while high
//   i_addr        out  32  IM address (= F_PC)
//   i_ready       in   1   IM response valid this cycle (combinational to i_req)
//   i_rdata       in   32  instruction word, valid when i_req & i_ready
//   F_PC          out  32  current fetch PC
//   D_PC          out  32  F/D register: PC of instr in D
//   D_instr       out  32  F/D register: instruction in D
//   D_valid       out  1   F/D register: 0 = bubble
// BEHAVIOUR
//   Reset (sync, any state, overrides all): F_PC<=RESET_PC, D_PC<=RESET_PC, D_instr<=NOP_INSTR,
//     D_valid<=0, state<=S_FETCH, skid and redirect cleared. i_ready in reset cycle ignored;
//     an in-flight fetch is abandoned.
//   FSM: S_FETCH (i_req=1, i_addr=F_PC) / S_HOLD (i_req=0, word parked in skid buffer).
//   fetch_done = S_FETCH & i_ready. adv = !F_stall.
//   S_FETCH, fetch_done, adv: D<={F_PC,i_rdata,1}; F_PC<=npc; stay S_FETCH.
//   S_FETCH, fetch_done, F_stall: skid<={F_PC,i_rdata}; ->S_HOLD; F_PC and D hold.
//   S_FETCH, !i_ready, adv: D<={F_PC,NOP_INSTR,0} (bubble); F_PC holds.
//   S_FETCH, !i_ready, F_stall: everything holds.
//   S_HOLD, adv: D<={skid,1}; F_PC<=npc; ->S_FETCH. S_HOLD, F_stall: hold.
//   npc selection (evaluated only when F_PC advances):
//     D_jump & adv (branch leaving D this cycle)  -> D_NPC_PCnext
//     else redir_valid                             -> redir_pc, clear redir_valid
//     else                                          -> F_PC+4 (32-bit wrap, no carry out)
//   Redirect latch: D_jump & adv while F_PC not advancing (fetch of delay slot pending)
//     -> redir_valid<=1, redir_pc<=D_NPC_PCnext. Applied when delay-slot fetch advances.
//   D_jump while F_stall=1 ignored (branch stays in D, re-presented next cycle).
//   Second D_jump while redir_valid=1 cannot occur (bubble in D); no special handling.
//   Targets: low 2 bits forced to 2'b00 before loading F_PC / redir_pc.
//   Latency: 1-cycle IM -> one instr per cycle, zero bubbles; N-cycle IM -> N-1 bubbles.
// STRUCTURE
//   Shared package/header: RESET_PC, NOP_INSTR, state encodings S_FETCH=1'b0, S_HOLD=1'b1.
//   One sub-module: fd_pipe_reg (D_PC/D_instr/D_valid with load/bubble/hold controls).
//   PC, FSM, skid and redirect logic stay in f_fetch_unit.
// TESTING
//   Reset, i_ready=1 always, no stall -> i_addr 0x3000,0x3004,0x3008; D_valid=1 from cycle 2.
//   i_ready low 2 cycles at 0x3004 -> D gets 2 bubbles (D_valid=0, D_instr=0), then 0x3004 word.
//   F_stall=1 for 3 cycles on fetch_done -> S_HOLD, i_req=0, D frozen; on release skid word enters D.
//   D_jump=1, D_NPC_PCnext=0x3100, delay slot fetch ready same cycle -> next i_addr 0x3100.
//   D_jump=1 target 0x3200 while delay-slot fetch waits 3 cycles -> slot delivered, then i_addr 0x3200.
//   reset asserted mid S_HOLD with redir_valid=1 -> next cycle i_addr 0x3000, D_valid=0, no redirect.

Source files
------------

// File: rtl/f_fetch_unit_pkg.sv
// Shared constants, FSM encoding and target alignment for the MIPS F-stage.
package f_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    // Control-transfer targets are always word aligned.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/f_fetch_unit_fd_pipe_reg.sv
// F/D pipeline register: loads a fetched word, inserts a bubble, or holds.
module fd_pipe_reg
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            D_PC    <= RESET_PC;
            D_instr <= NOP_INSTR;
            D_valid <= 1'b0;
        end else if (load) begin
            D_PC    <= pc;
            D_instr <= instr;
            D_valid <= 1'b1;
        end else if (bubble) begin
            D_PC    <= pc;
            D_instr <= NOP_INSTR;
            D_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// MIPS F-stage: fetch PC, IM request/ready handshake, skid buffer for stalled
// responses and a latched redirect for branches whose delay slot is still in flight.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic        D_jump,
    input  logic [31:0] D_NPC_PCnext,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic        i_ready,
    input  logic [31:0] i_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid
);

    state_t      state;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        redir_valid;
    logic [31:0] redir_pc;

    logic        adv;
    logic        fetch_done;
    logic        pc_adv;
    logic        take_jump;
    logic [31:0] npc;
    logic        fd_load;
    logic        fd_bubble;
    logic [31:0] fd_pc;
    logic [31:0] fd_instr;

    always_comb begin
        adv        = !F_stall;
        fetch_done = (state == S_FETCH) && i_ready;
        pc_adv     = adv && (fetch_done || (state == S_HOLD));
        take_jump  = D_jump && adv;

        // A branch leaving D wins; otherwise a redirect parked while the
        // delay slot was pending; otherwise sequential.
        if (take_jump) begin
            npc = align_target(D_NPC_PCnext);
        end else if (redir_valid) begin
            npc = redir_pc;
        end else begin
            npc = F_PC + 32'd4;
        end

        fd_load   = pc_adv;
        fd_bubble = adv && (state == S_FETCH) && !i_ready;
        fd_pc     = (state == S_HOLD) ? skid_pc    : F_PC;
        fd_instr  = (state == S_HOLD) ? skid_instr : i_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            F_PC        <= RESET_PC;
            skid_pc     <= RESET_PC;
            skid_instr  <= NOP_INSTR;
            redir_valid <= 1'b0;
            redir_pc    <= RESET_PC;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_done && F_stall) begin
                        state      <= S_HOLD;
                        skid_pc    <= F_PC;
                        skid_instr <= i_rdata;
                    end
                end
                S_HOLD: begin
                    if (adv) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase

            if (pc_adv) begin
                F_PC <= npc;
                if (!take_jump) begin
                    redir_valid <= 1'b0;
                end
            end else if (take_jump) begin
                // Delay slot not yet fetched: remember where to go after it.
                redir_valid <= 1'b1;
                redir_pc    <= align_target(D_NPC_PCnext);
            end
        end
    end

    assign i_req  = (state == S_FETCH);
    assign i_addr = F_PC;

    fd_pipe_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_pipe_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (fd_load),
        .bubble  (fd_bubble),
        .pc      (fd_pc),
        .instr   (fd_instr),
        .D_PC    (D_PC),
        .D_instr (D_instr),
        .D_valid (D_valid)
    );

endmodule
